// File: rtl/issue_ctrl.sv
// In-order single-issue front end: fetch, decode wait, scoreboard-gated issue,
// branch resolution wait and halt, with scalar and predicate pending-write tracking.
module issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int REG_SEL = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_req,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic               imem_valid,
    input  logic [WIDTH-1:0]   imem_rdata,
    output logic [WIDTH-1:0]   inst,
    input  logic               dec_halted,
    input  logic               dec_is_branch,
    input  logic               dec_a_from_regbank,
    input  logic               dec_b_from_regbank,
    input  logic               dec_a_regbank_sel,
    input  logic               dec_z_regbank_sel,
    input  logic [REG_SEL-1:0] dec_a_regbank_addr,
    input  logic [REG_SEL-1:0] dec_b_regbank_addr,
    input  logic [REG_SEL-1:0] dec_z_regbank_addr,
    output logic               issue_valid,
    input  logic               issue_ready,
    input  logic               wb_valid,
    input  logic               wb_regbank_sel,
    input  logic [REG_SEL-1:0] wb_regbank_addr,
    input  logic               br_valid,
    input  logic               br_taken,
    input  logic [WIDTH-1:0]   br_target,
    output logic               halted,
    output logic               busy
);

    localparam int NSCAL = 1 << REG_SEL;

    // state   | meaning
    // IDLE    | waiting for start
    // FETCH   | imem request outstanding for pc
    // DECODE  | decoder settling on the latched instruction
    // ISSUE   | offering instruction, gated by the scoreboard
    // BRWAIT  | branch issued, waiting for its resolution
    // HALTED  | halt retired with a clear scoreboard, only rst leaves
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_BRWAIT,
        S_HALTED
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [WIDTH-1:0]   inst_q, inst_d;
    logic [NSCAL-1:0]   pend_s_q, pend_s_d;
    logic [15:0]        pend_p_q, pend_p_d;

    logic haz_a, haz_b, haz_z, hazard, handshake, sb_clear;

    always_comb begin
        haz_a = dec_a_regbank_sel ? pend_p_q[dec_a_regbank_addr[3:0]]
                                  : pend_s_q[dec_a_regbank_addr];
        haz_b = pend_s_q[dec_b_regbank_addr];
        haz_z = dec_z_regbank_sel ? pend_p_q[dec_z_regbank_addr[3:0]]
                                  : pend_s_q[dec_z_regbank_addr];
        hazard = (dec_a_from_regbank && haz_a)
               || (dec_b_from_regbank && haz_b)
               || (!dec_is_branch && !dec_halted && haz_z);
        sb_clear = (pend_s_q == '0) && (pend_p_q == '0);
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign inst        = inst_q;
    assign issue_valid = (state_q == S_ISSUE) && !hazard && !dec_halted;
    assign handshake   = issue_valid && issue_ready;
    assign halted      = (state_q == S_HALTED);
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_valid) begin
                    inst_d  = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_ISSUE;
            S_ISSUE: begin
                if (dec_halted) begin
                    if (sb_clear) state_d = S_HALTED;
                end else if (handshake) begin
                    if (dec_is_branch) begin
                        state_d = S_BRWAIT;
                    end else begin
                        pc_d    = pc_q + WIDTH'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_BRWAIT: begin
                if (br_valid) begin
                    pc_d    = br_taken ? br_target : pc_q + WIDTH'(1);
                    state_d = S_FETCH;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Clear first, then set, so an issue to a register completing in the same cycle stays pending.
    always_comb begin
        pend_s_d = pend_s_q;
        pend_p_d = pend_p_q;
        if (wb_valid) begin
            if (wb_regbank_sel) pend_p_d[wb_regbank_addr[3:0]] = 1'b0;
            else                pend_s_d[wb_regbank_addr]      = 1'b0;
        end
        if (handshake && !dec_is_branch) begin
            if (dec_z_regbank_sel) pend_p_d[dec_z_regbank_addr[3:0]] = 1'b1;
            else                   pend_s_d[dec_z_regbank_addr]      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            inst_q   <= '0;
            pend_s_q <= '0;
            pend_p_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pend_s_q <= pend_s_d;
            pend_p_q <= pend_p_d;
        end
    end

endmodule
